// File: rtl/nfc_rb_pkg.sv
// Shared definitions for the NFC ready/busy monitor: way FSM encoding and
// a width helper for the glitch-filter counter.
`timescale 1ns/1ps
package nfc_rb_pkg;

    typedef enum logic [1:0] {
        RB_IDLE      = 2'd0,
        RB_WAIT_BUSY = 2'd1,
        RB_BUSY      = 2'd2
    } rb_state_e;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/nfc_rb_way.sv
// One R/B# way: synchroniser, glitch filter and busy-tracking FSM that
// produces completion events and a sticky busy-timeout flag.
`timescale 1ns/1ps
module nfc_rb_way
    import nfc_rb_pkg::*;
#(
    parameter int SyncStages     = 2,
    parameter int FilterCycles   = 4,
    parameter int WBWindowCycles = 32,
    parameter int TimeoutWidth   = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pin,
    input  logic                    arm,
    input  logic [TimeoutWidth-1:0] timeout_value,
    input  logic                    clear_timeout,
    output logic                    ready_busy,
    output logic                    way_busy,
    output logic                    ready_event,
    output logic                    timeout
);

    localparam int FiltW = clog2_min1(FilterCycles);
    localparam logic [FiltW-1:0]        FiltLast = FiltW'(FilterCycles - 1);
    localparam logic [TimeoutWidth-1:0] WbLast   = TimeoutWidth'(WBWindowCycles - 1);

    logic [SyncStages-1:0] sync_q;
    logic                  sync_out;
    logic [FiltW-1:0]      filt_cnt;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SyncStages-2:0], pin};
    end

    assign sync_out = sync_q[SyncStages-1];

    // Level flips only after FilterCycles consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt   <= '0;
            ready_busy <= 1'b0;
        end else if (sync_out != ready_busy) begin
            if (filt_cnt == FiltLast) begin
                filt_cnt   <= '0;
                ready_busy <= sync_out;
            end else begin
                filt_cnt <= filt_cnt + FiltW'(1);
            end
        end else begin
            filt_cnt <= '0;
        end
    end

    rb_state_e                 state, state_nxt;
    logic [TimeoutWidth-1:0]   cnt, cnt_nxt, cnt_sat;
    logic                      event_nxt, timeout_nxt;

    assign cnt_sat = (cnt == '1) ? cnt : cnt + TimeoutWidth'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RB_IDLE;
            cnt         <= '0;
            ready_event <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ready_event <= event_nxt;
            timeout     <= timeout_nxt;
        end
    end

    // Arm overrides everything, including a coincident completion or timeout.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        event_nxt   = 1'b0;
        timeout_nxt = timeout;
        if (arm) begin
            state_nxt   = RB_WAIT_BUSY;
            cnt_nxt     = '0;
            timeout_nxt = 1'b0;
        end else begin
            if (clear_timeout) timeout_nxt = 1'b0;
            case (state)
                RB_IDLE: ;
                RB_WAIT_BUSY: begin
                    if (!ready_busy) begin
                        state_nxt = RB_BUSY;
                        cnt_nxt   = '0;
                    end else if (cnt == WbLast) begin
                        state_nxt = RB_IDLE;
                        cnt_nxt   = '0;
                        event_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_sat;
                    end
                end
                RB_BUSY: begin
                    if (ready_busy) begin
                        state_nxt = RB_IDLE;
                        cnt_nxt   = '0;
                        event_nxt = 1'b1;
                    end else if ((timeout_value != '0) &&
                                 (cnt == timeout_value - TimeoutWidth'(1))) begin
                        state_nxt   = RB_IDLE;
                        cnt_nxt     = '0;
                        timeout_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_sat;
                    end
                end
                default: state_nxt = RB_IDLE;
            endcase
        end
    end

    assign way_busy = (state != RB_IDLE);

endmodule

// File: rtl/nfc_ready_busy_monitor.sv
// Per-way R/B# monitor: one nfc_rb_way per CE way plus a registered
// all-ways-ready summary for the way scheduler.
`timescale 1ns/1ps
module nfc_ready_busy_monitor
    import nfc_rb_pkg::*;
#(
    parameter int NumberOfWays   = 4,
    parameter int SyncStages     = 2,
    parameter int FilterCycles   = 4,
    parameter int WBWindowCycles = 32,
    parameter int TimeoutWidth   = 24
) (
    input  logic                    iSystemClock,
    input  logic                    iModuleReset,
    input  logic [NumberOfWays-1:0] I_NAND_RB,
    input  logic [NumberOfWays-1:0] iWayArm,
    input  logic [TimeoutWidth-1:0] iTimeoutValue,
    input  logic [NumberOfWays-1:0] iClearTimeout,
    output logic [NumberOfWays-1:0] oReadyBusy,
    output logic [NumberOfWays-1:0] oWayBusy,
    output logic [NumberOfWays-1:0] oReadyEvent,
    output logic [NumberOfWays-1:0] oTimeout,
    output logic                    oAllReady
);

    for (genvar i = 0; i < NumberOfWays; i++) begin : g_way
        nfc_rb_way #(
            .SyncStages     (SyncStages),
            .FilterCycles   (FilterCycles),
            .WBWindowCycles (WBWindowCycles),
            .TimeoutWidth   (TimeoutWidth)
        ) u_way (
            .clk           (iSystemClock),
            .rst           (iModuleReset),
            .pin           (I_NAND_RB[i]),
            .arm           (iWayArm[i]),
            .timeout_value (iTimeoutValue),
            .clear_timeout (iClearTimeout[i]),
            .ready_busy    (oReadyBusy[i]),
            .way_busy      (oWayBusy[i]),
            .ready_event   (oReadyEvent[i]),
            .timeout       (oTimeout[i])
        );
    end

    always_ff @(posedge iSystemClock) begin
        if (iModuleReset) oAllReady <= 1'b0;
        else              oAllReady <= &(oReadyBusy & ~oWayBusy);
    end

endmodule

// File: tb/tb_nfc_ready_busy_monitor.sv
// Bench for nfc_ready_busy_monitor: directed scenarios plus random pin/arm
// traffic, checked each cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_nfc_ready_busy_monitor;

    localparam int NW = 4, S = 2, F = 4, WB = 32, TW = 24;
    localparam int M_IDLE = 0, M_WAIT = 1, M_BUSY = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NW-1:0] pin = '0, arm = '0, clr = '0;
    logic [TW-1:0] tval = '0;
    logic [NW-1:0] rdy, busy, ev, tmo;
    logic          all_rdy;

    always #5 clk = ~clk;

    nfc_ready_busy_monitor #(
        .NumberOfWays(NW), .SyncStages(S), .FilterCycles(F),
        .WBWindowCycles(WB), .TimeoutWidth(TW)
    ) dut (
        .iSystemClock (clk),
        .iModuleReset (rst),
        .I_NAND_RB    (pin),
        .iWayArm      (arm),
        .iTimeoutValue(tval),
        .iClearTimeout(clr),
        .oReadyBusy   (rdy),
        .oWayBusy     (busy),
        .oReadyEvent  (ev),
        .oTimeout     (tmo),
        .oAllReady    (all_rdy)
    );

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: filter as a sliding window over delayed pin history,
    // way tracking as timestamps of arm / busy entry.
    logic [NW-1:0] m_rb = '0, m_busy = '0, m_ev = '0, m_tmo = '0;
    logic          m_all = 1'b0;
    int            mode[NW];
    int            t_arm[NW], t_busy[NW];
    bit            hist[NW][$];
    int            now = 0;

    function automatic void model_update(input logic [NW-1:0] p, a, c, input logic r);
        logic [NW-1:0] rb_next;
        bit            diff;
        now++;
        if (r) begin
            m_rb = '0; m_busy = '0; m_ev = '0; m_tmo = '0; m_all = 1'b0;
            for (int w = 0; w < NW; w++) begin
                mode[w] = M_IDLE;
                hist[w].delete();
                repeat (S + F) hist[w].push_back(1'b0);
            end
            return;
        end
        m_all = &(m_rb & ~m_busy);
        rb_next = m_rb;
        for (int w = 0; w < NW; w++) begin
            diff = 1'b1;
            for (int k = 0; k < F; k++)
                if (hist[w][hist[w].size() - S - k] == m_rb[w]) diff = 1'b0;
            if (diff) rb_next[w] = ~m_rb[w];
            hist[w].push_back(p[w]);
            if (hist[w].size() > S + F + 4) void'(hist[w].pop_front());
            m_ev[w] = 1'b0;
            if (a[w]) begin
                mode[w]  = M_WAIT;
                t_arm[w] = now;
                m_tmo[w] = 1'b0;
            end else begin
                if (c[w]) m_tmo[w] = 1'b0;
                if (mode[w] == M_WAIT) begin
                    if (!m_rb[w]) begin
                        mode[w] = M_BUSY; t_busy[w] = now;
                    end else if (now - t_arm[w] == WB) begin
                        mode[w] = M_IDLE; m_ev[w] = 1'b1;
                    end
                end else if (mode[w] == M_BUSY) begin
                    if (m_rb[w]) begin
                        mode[w] = M_IDLE; m_ev[w] = 1'b1;
                    end else if (tval != 0 && now - t_busy[w] == int'(tval)) begin
                        mode[w] = M_IDLE; m_tmo[w] = 1'b1;
                    end
                end
            end
            m_busy[w] = (mode[w] != M_IDLE);
        end
        m_rb = rb_next;
    endfunction

    task automatic step(input logic [NW-1:0] p, a, c, input logic r);
        pin = p; arm = a; clr = c; rst = r;
        @(posedge clk);
        model_update(p, a, c, r);
        #1;
        chk("ready_busy", rdy, m_rb);
        chk("way_busy", busy, m_busy);
        chk("ready_event", ev, m_ev);
        chk("timeout", tmo, m_tmo);
        chk("all_ready", all_rdy, m_all);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        bit seen, dropped;
        logic [NW-1:0] p, a, c;
        int hold[NW];

        // Reset, then all pins ready: filtered level rises S+F samples later.
        repeat (3) step('0, '0, '0, 1'b1);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            step('1, '0, '0, 1'b0);
            if (lat < 0 && rdy == '1) lat = i;
        end
        chk("rise_latency", lat, S + F);

        // Short glitch is swallowed, a long one passes with full latency.
        dropped = 0;
        repeat (3) step(4'b1110, '0, '0, 1'b0);
        repeat (12) begin step('1, '0, '0, 1'b0); if (!rdy[0]) dropped = 1; end
        chk("glitch3", dropped, 0);
        lat = -1;
        for (int i = 1; i <= 4; i++) begin
            step(4'b1110, '0, '0, 1'b0);
            if (lat < 0 && !rdy[0]) lat = i;
        end
        for (int i = 5; i <= 12; i++) begin
            step('1, '0, '0, 1'b0);
            if (lat < 0 && !rdy[0]) lat = i;
        end
        chk("glitch4_fall", lat, S + F);
        repeat (4) step('1, '0, '0, 1'b0);

        // Normal operation on way 1.
        step('1, 4'b0010, '0, 1'b0);
        repeat (4) step('1, '0, '0, 1'b0);
        repeat (100) step(4'b1101, '0, '0, 1'b0);
        repeat (15) step('1, '0, '0, 1'b0);

        // Busy never observed on way 2: completion after the tWB window.
        step('1, 4'b0100, '0, 1'b0);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step('1, '0, '0, 1'b0);
            if (lat < 0 && ev[2]) lat = i;
        end
        chk("wb_window", lat, WB);

        // Timeout on way 3, then a timeout coincident with a clear request.
        tval = 24'd50;
        step('1, '0, '0, 1'b1);
        repeat (8) step('1, '0, '0, 1'b0);
        step(4'b0111, 4'b1000, '0, 1'b0);
        lat = -1;
        for (int i = 1; i <= 70 && lat < 0; i++) begin
            step(4'b0111, '0, '0, 1'b0);
            if (tmo[3]) lat = i;
        end
        chk("timeout_latency", lat, S + F + 50);
        step(4'b0111, 4'b1000, '0, 1'b0);
        repeat (50) step(4'b0111, '0, '0, 1'b0);
        step(4'b0111, '0, 4'b1000, 1'b0);
        chk("timeout_set_wins", tmo[3], 1'b1);
        step(4'b0111, '0, 4'b1000, 1'b0);

        // Re-arm way 0 on the very edge its operation completes.
        step(4'b0110, 4'b0001, '0, 1'b0);
        repeat (12) step(4'b0110, '0, '0, 1'b0);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (m_rb[0] && mode[0] == M_BUSY) begin
                step(4'b0111, 4'b0001, '0, 1'b0);
                seen = 1;
                chk("rearm_no_event", ev[0], 1'b0);
                chk("rearm_busy", busy[0], 1'b1);
            end else begin
                step(4'b0111, '0, '0, 1'b0);
            end
        end
        chk("rearm_hit", seen, 1'b1);
        repeat (40) step(4'b0111, '0, '0, 1'b0);

        // Reset in the middle of a busy operation.
        step(4'b0101, 4'b0010, '0, 1'b0);
        repeat (20) step(4'b0101, '0, '0, 1'b0);
        step(4'b0101, '0, '0, 1'b1);
        chk("reset_mid_busy", {rdy, busy, ev, tmo, all_rdy}, '0);

        // Random traffic: per-way pin levels held for random lengths.
        for (int w = 0; w < NW; w++) hold[w] = 0;
        p = '1;
        for (int n = 0; n < 5000; n++) begin
            for (int w = 0; w < NW; w++) begin
                if (hold[w] == 0) begin
                    p[w] = 1'($urandom_range(0, 1));
                    hold[w] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                           : $urandom_range(10, 120);
                end else begin
                    hold[w]--;
                end
                a[w] = ($urandom_range(0, 59) == 0);
                c[w] = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 1499) == 0) begin
                case ($urandom_range(0, 3))
                    0: tval = 24'd0;
                    1: tval = 24'd7;
                    2: tval = 24'd20;
                    default: tval = 24'd50;
                endcase
                step(p, a, c, 1'b1);
            end else begin
                step(p, a, c, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
